aq_spsram_param: RTL
====================

Name: aq_spsram_param

Overview:
- Parametrised single-port SRAM macro model for FPGA builds; next generation of the fixed-geometry LSU/cache SRAM wrappers.
- Adds configurable depth, width and write-mask granularity, plus an optional output pipeline register.
- Adds a hardware init-clear engine, because FPGA block RAM powers up unknown and tag/valid arrays need a known value.
- Instantiated directly by LSU tag, data and dirty arrays in place of per-size wrappers.

Parameters:
ADDR_WIDTH, 6, address bits; depth DEPTH = 2**ADDR_WIDTH entries
DATA_WIDTH, 58, data bits per entry
WE_WIDTH, 58, write-mask bits; must divide DATA_WIDTH; each mask bit covers SLICE = DATA_WIDTH/WE_WIDTH data bits
OUT_REG, 0, 0 gives 1-cycle read latency; 1 adds an output register for 2-cycle latency
INIT_VAL, 0, value written to every entry during clear (DATA_WIDTH bits, zero-extended)

Ports:
CLK  input  1  clock; all state updates on the rising edge
RST_B  input  1  asynchronous active-low reset
A  input  ADDR_WIDTH  access address
CEN  input  1  chip enable, active-low
GWEN  input  1  global write enable, active-low; 1 means read
WEN  input  WE_WIDTH  per-slice write enable, active-low; bit i covers D[i*SLICE +: SLICE]
D  input  DATA_WIDTH  write data
INIT_REQ  input  1  pulse; restarts the clear sweep when idle
Q  output  DATA_WIDTH  read data; holds its value between reads
QVLD  output  1  one-cycle pulse when Q takes new read data
INIT_BUSY  output  1  clear sweep in progress; external accesses ignored

Behaviour:
- Reset (RST_B=0, async):
  - Q=0, QVLD=0, INIT_BUSY=1, FSM=CLEAR, sweep counter=0.
  - Pipeline stage is cleared; an in-flight read is discarded.
  - The memory array itself is not reset.
- FSM states: CLEAR and IDLE.
- CLEAR:
  - Each cycle writes INIT_VAL to mem[cnt], then cnt++.
  - At cnt==DEPTH-1 the write completes and the next state is IDLE.
  - INIT_BUSY deasserts on the edge that completes the last write, so it is high for exactly DEPTH cycles after reset release.
  - CEN, GWEN, WEN, D and A are ignored throughout. Q is held and QVLD=0.
  - INIT_REQ is ignored (no restart).
- IDLE:
  - INIT_REQ=1 sets FSM=CLEAR and cnt=0; INIT_BUSY rises next cycle. Any access presented in that same cycle is still performed.
  - Read (CEN=0, GWEN=1): mem[A] reaches Q after 1 edge (OUT_REG=0) or 2 edges (OUT_REG=1), with QVLD high in the same cycle Q updates.
  - Write (CEN=0, GWEN=0): for each i with WEN[i]=0, slice i of mem[A] takes the matching slice of D; other slices are unchanged. Q and QVLD are not affected; there is no write-through.
  - CEN=1: no access; Q holds.
- Read of an address in the cycle after a write to it returns the new data (no hazard).
- Back-to-back reads with OUT_REG=1 are fully pipelined: one result per cycle.
- Width rules:
  - cnt is ADDR_WIDTH+1 bits, so the terminal compare does not wrap.
  - Elaboration fails if DATA_WIDTH % WE_WIDTH != 0.
- Reset mid-sweep or mid-read: returns to the reset state and the sweep restarts from address 0.

Decomposition:
- Shared package aq_spsram_pkg holds:
  - FSM state encoding (CLEAR=1'b1, IDLE=1'b0);
  - the helper function computing SLICE;
  - the elaboration-check macro for the divisibility rule.
- One sub-module: aq_spsram_init_fsm, containing the state register, sweep counter and INIT_BUSY, and emitting an internal write-address/strobe override.
- The top level muxes that override against the external port and holds the array and output stage.

Test Plan:
1. Reset release with DEPTH=64 and INIT_VAL=0x3 -> INIT_BUSY high for 64 cycles; then reads of addresses 0, 31 and 63 each return 0x3 with QVLD pulsing.
2. Write 0x2AAAAAAAAAAAAAA to address 5 with WEN all 0, then read address 5 -> Q=0x2AAAAAAAAAAAAAA after 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1); Q holds through the following idle cycles.
3. WE_WIDTH=2 with DATA_WIDTH=58: write all ones, then write all zeros with WEN=2'b10 -> read returns the upper 29 bits set and the lower 29 bits clear.
4. Write to address 9 during INIT_BUSY -> write ignored; address 9 reads INIT_VAL after the sweep.
5. INIT_REQ in IDLE issued together with a read of address 7 -> the read returns the old data; INIT_BUSY is high the next cycle for 64 cycles; address 7 then reads INIT_VAL.
6. Assert RST_B=0 at sweep count 20, then release -> Q=0 immediately and INIT_BUSY stays high for a full 64 cycles after release.
7. OUT_REG=1 with reads of addresses 1, 2 and 3 on consecutive cycles -> Q takes the three values on cycles 2, 3 and 4, with QVLD high on all three.

Source files
------------

// File: rtl/aq_spsram_pkg.sv
// Shared definitions for the parametrised single-port SRAM model:
// sweep FSM encoding, slice-width helper and the mask-divisibility check.
`ifndef AQ_SPSRAM_CHECK_DIV
`define AQ_SPSRAM_CHECK_DIV(DW, WW) \
  if (((DW) % (WW)) != 0) begin : g_div_check \
    $error("aq_spsram: DATA_WIDTH must be a multiple of WE_WIDTH"); \
  end
`endif

package aq_spsram_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  function automatic int slice_width(input int dw, input int ww);
    return dw / ww;
  endfunction

endpackage

// File: rtl/aq_spsram_if.sv
// Access port of the single-port SRAM: address/control/data in,
// read data, read-valid pulse and clear-busy out.
interface aq_spsram_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 58,
  parameter int WE_WIDTH   = 58
);
  logic [ADDR_WIDTH-1:0] A;
  logic                  CEN;
  logic                  GWEN;
  logic [WE_WIDTH-1:0]   WEN;
  logic [DATA_WIDTH-1:0] D;
  logic                  INIT_REQ;
  logic [DATA_WIDTH-1:0] Q;
  logic                  QVLD;
  logic                  INIT_BUSY;

  modport master (
    output A, CEN, GWEN, WEN, D, INIT_REQ,
    input  Q, QVLD, INIT_BUSY
  );

  modport slave (
    input  A, CEN, GWEN, WEN, D, INIT_REQ,
    output Q, QVLD, INIT_BUSY
  );
endinterface

// File: rtl/aq_spsram_init_fsm.sv
// Init-clear sequencer: sweeps every address once after reset or on request,
// supplying the write address/strobe that overrides the external port.
module aq_spsram_init_fsm
  import aq_spsram_pkg::*;
#(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  init_req_i,
  output logic                  busy_o,
  output logic                  init_we_o,
  output logic [ADDR_WIDTH-1:0] init_addr_o
);

  // One extra counter bit keeps the terminal compare clear of wrap-around.
  localparam logic [ADDR_WIDTH:0] LAST = {1'b0, {ADDR_WIDTH{1'b1}}};

  state_e              state_q;
  logic [ADDR_WIDTH:0] cnt_q;
  logic                busy_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (cnt_q == LAST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + (ADDR_WIDTH+1)'(1);
          end
        end
        ST_IDLE: begin
          if (init_req_i) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign init_we_o   = (state_q == ST_CLEAR);
  assign init_addr_o = cnt_q[ADDR_WIDTH-1:0];

endmodule

// File: rtl/aq_spsram_param.sv
// Parametrised single-port SRAM with per-slice write mask, optional output
// register and a hardware clear engine so the array powers up known.
module aq_spsram_param
  import aq_spsram_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    DATA_WIDTH = 58,
  parameter int                    WE_WIDTH   = 58,
  parameter int                    OUT_REG    = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input logic        CLK,
  input logic        RST_B,
  aq_spsram_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int SLICE = slice_width(DATA_WIDTH, WE_WIDTH);

  `AQ_SPSRAM_CHECK_DIV(DATA_WIDTH, WE_WIDTH)

  logic                  busy;
  logic                  init_we;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic                  rd_en;
  logic                  wr_en;
  logic [WE_WIDTH-1:0]   slice_we;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic [DATA_WIDTH-1:0] q_q;
  logic                  qvld_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  aq_spsram_init_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_init_fsm (
    .clk_i       (CLK),
    .rst_n_i     (RST_B),
    .init_req_i  (bus.INIT_REQ),
    .busy_o      (busy),
    .init_we_o   (init_we),
    .init_addr_o (init_addr)
  );

  assign rd_en = ~busy & ~bus.CEN & bus.GWEN;
  assign wr_en = ~busy & ~bus.CEN & ~bus.GWEN;

  // The sweep owns the write port while busy; external writes are dropped.
  always_comb begin
    slice_we = '0;
    wr_data  = bus.D;
    wr_addr  = bus.A;
    if (init_we) begin
      slice_we = '1;
      wr_data  = INIT_VAL;
      wr_addr  = init_addr;
    end else if (wr_en) begin
      slice_we = ~bus.WEN;
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < WE_WIDTH; i++) begin
      if (slice_we[i]) begin
        mem[wr_addr][i*SLICE +: SLICE] <= wr_data[i*SLICE +: SLICE];
      end
    end
  end

  assign rd_data_d = mem[bus.A];

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_WIDTH-1:0] pipe_data_q;
    logic                  pipe_vld_q;

    always_ff @(posedge CLK or negedge RST_B) begin
      if (!RST_B) begin
        pipe_data_q <= '0;
        pipe_vld_q  <= 1'b0;
        q_q         <= '0;
        qvld_q      <= 1'b0;
      end else begin
        pipe_vld_q <= rd_en;
        if (rd_en) pipe_data_q <= rd_data_d;
        qvld_q <= pipe_vld_q;
        if (pipe_vld_q) q_q <= pipe_data_q;
      end
    end
  end else begin : g_noreg
    always_ff @(posedge CLK or negedge RST_B) begin
      if (!RST_B) begin
        q_q    <= '0;
        qvld_q <= 1'b0;
      end else begin
        qvld_q <= rd_en;
        if (rd_en) q_q <= rd_data_d;
      end
    end
  end

  assign bus.Q         = q_q;
  assign bus.QVLD      = qvld_q;
  assign bus.INIT_BUSY = busy;

endmodule
